// File: rtl/i3c_daa_pkg.sv
// i3c_daa_pkg: shared state encoding, field sizes and parity helper for the ENTDAA responder
package i3c_daa_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_ACK, S_LOST} daa_state_t;
  localparam int ID_BITS = 64;
  localparam int DA_BITS = 7;
  localparam int BCR_OFS = 8;
  localparam int DCR_OFS = 0;
  function automatic logic odd_par(input logic [DA_BITS-1:0] a);
    return ~^a;
  endfunction
endpackage

// File: rtl/i3c_daa_arb_mask.sv
// i3c_daa_arb_mask: wired-AND of contender ID bits, next contender mask and lowest contender index
module i3c_daa_arb_mask
  import i3c_daa_pkg::*;
#(
  parameter int NUM_TGT = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_TGT-1:0]         mask,
  input  logic [ID_BITS*NUM_TGT-1:0] tgt_id,
  input  logic [5:0]                 cnt,
  input  logic                       sda_in,
  output logic [NUM_TGT-1:0]         next_mask,
  output logic                       wbit,
  output logic [IDX_W-1:0]           low_idx
);
  logic [ID_BITS-1:0] id_w [NUM_TGT];
  for (genvar g = 0; g < NUM_TGT; g++) begin : g_id
    assign id_w[g] = tgt_id[g*ID_BITS +: ID_BITS];
  end
  // a contender drops out when it offers a 1 but the bus carries 0; scanning downward leaves the lowest index
  always_comb begin
    next_mask = mask;
    wbit      = 1'b1;
    low_idx   = '0;
    for (int i = NUM_TGT-1; i >= 0; i--) begin
      next_mask[i] = mask[i] & ~(id_w[i][cnt] & ~sda_in);
      if (mask[i]) begin
        wbit    = wbit & id_w[i][cnt];
        low_idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/i3c_daa_multi_slave.sv
// i3c_daa_multi_slave: ENTDAA responder for NUM_TGT virtual targets; define I3C_DAA_ERRCNT_EN for the parity-NACK counter
module i3c_daa_multi_slave
  import i3c_daa_pkg::*;
#(
  parameter int NUM_TGT = 2,
  parameter int IDX_W   = 1,
  parameter int ERR_W   = 4
) (
  input  logic                       clk_SCL,
  input  logic                       RSTn,
  input  logic                       bit_tick,
  input  logic                       sda_in,
  input  logic                       daa_active,
  input  logic                       daa_rstart,
  input  logic                       rstdaa,
  input  logic                       set_da,
  input  logic [IDX_W-1:0]           set_idx,
  input  logic [DA_BITS-1:0]         new_da,
  input  logic [ID_BITS*NUM_TGT-1:0] tgt_id,
  output logic                       drv_en,
  output logic                       drv_bit,
  output logic [8*NUM_TGT-1:0]       tgt_dyn_addr,
  output logic                       da_chg,
  output logic [IDX_W-1:0]           da_chg_idx,
  output logic                       all_assigned,
  output logic [ERR_W-1:0]           err_cnt
);
  daa_state_t         state;
  logic [5:0]         cnt;
  logic [NUM_TGT-1:0] mask, next_mask, valid;
  logic [7:1]         addr, pend_da;
  logic               par, wbit, pend_v;
  logic [IDX_W-1:0]   low_idx, pend_idx;
  logic [7:0]         dyn [NUM_TGT];

  i3c_daa_arb_mask #(.NUM_TGT(NUM_TGT), .IDX_W(IDX_W)) u_arb (
    .mask      (mask),
    .tgt_id    (tgt_id),
    .cnt       (cnt),
    .sda_in    (sda_in),
    .next_mask (next_mask),
    .wbit      (wbit),
    .low_idx   (low_idx)
  );

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_tbl
    assign valid[g]                 = dyn[g][0];
    assign tgt_dyn_addr[8*g +: 8]   = dyn[g];
  end

  assign all_assigned = &valid;

  logic             par_ok, ack_tick, commit_req;
  logic [IDX_W-1:0] cm_idx;
  logic [7:1]       cm_da;
  assign par_ok     = par == odd_par(addr);
  assign ack_tick   = state == S_ACK && bit_tick && daa_active;
  assign commit_req = (ack_tick && par_ok) || pend_v;
  assign cm_idx     = pend_v ? pend_idx : low_idx;
  assign cm_da      = pend_v ? pend_da : addr;

  // DAA round sequencing with registered SDA drive, one cycle behind the state it reflects
  always_ff @(posedge clk_SCL) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mask    <= '0;
      addr    <= '0;
      par     <= 1'b0;
      drv_en  <= 1'b0;
      drv_bit <= 1'b1;
    end else if (!daa_active) begin
      state   <= S_IDLE;
      drv_en  <= 1'b0;
      drv_bit <= 1'b1;
    end else begin
      drv_en  <= state == S_ID || state == S_ACK;
      drv_bit <= state == S_ID ? wbit : state == S_ACK ? ~par_ok : 1'b1;
      case (state)
        S_IDLE: if (daa_rstart) begin
          if (all_assigned) state <= S_LOST;
          else begin
            state <= S_ID;
            mask  <= ~valid;
            cnt   <= 6'd63;
          end
        end
        S_ID: if (bit_tick) begin
          mask <= next_mask;
          if (next_mask == '0) state <= S_LOST;
          else if (cnt == 6'd0) begin
            state <= S_ADDR;
            cnt   <= 6'd7;
          end else cnt <= cnt - 6'd1;
        end
        S_ADDR: if (bit_tick) begin
          if (cnt == 6'd0) begin
            par   <= sda_in;
            state <= S_ACK;
          end else begin
            addr[cnt[2:0]] <= sda_in;
            cnt            <= cnt - 6'd1;
          end
        end
        S_ACK: if (bit_tick) state <= S_IDLE;
        default: if (daa_rstart) state <= S_IDLE;
      endcase
    end
  end

  // address table: rstdaa beats set_da beats commit; a commit displaced by set_da to another index waits one cycle
  always_ff @(posedge clk_SCL) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_TGT; i++) dyn[i] <= '0;
      da_chg     <= 1'b0;
      da_chg_idx <= '0;
      pend_v     <= 1'b0;
      pend_idx   <= '0;
      pend_da    <= '0;
    end else if (rstdaa) begin
      for (int i = 0; i < NUM_TGT; i++) dyn[i] <= '0;
      da_chg     <= 1'b1;
      da_chg_idx <= '1;
      pend_v     <= 1'b0;
    end else if (set_da) begin
      dyn[set_idx] <= {new_da, 1'b1};
      da_chg       <= 1'b1;
      da_chg_idx   <= set_idx;
      pend_v       <= commit_req && cm_idx != set_idx;
      pend_idx     <= cm_idx;
      pend_da      <= cm_da;
    end else if (commit_req) begin
      dyn[cm_idx] <= {cm_da, 1'b1};
      da_chg      <= 1'b1;
      da_chg_idx  <= cm_idx;
      pend_v      <= 1'b0;
    end else begin
      da_chg <= 1'b0;
      pend_v <= 1'b0;
    end
  end

`ifdef I3C_DAA_ERRCNT_EN
  // saturating count of parity NACKs
  always_ff @(posedge clk_SCL) begin
    if (!RSTn || rstdaa) err_cnt <= '0;
    else if (ack_tick && !par_ok && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_i3c_daa_multi_slave.sv
// tb_i3c_daa_multi_slave: directed ENTDAA rounds against hand-computed addresses and drive values
module tb_i3c_daa_multi_slave;
  logic         clk_SCL = 0, RSTn = 0, bit_tick = 0, sda_in = 1;
  logic         daa_active = 0, daa_rstart = 0, rstdaa = 0, set_da = 0;
  logic [0:0]   set_idx = '0;
  logic [6:0]   new_da = '0;
  logic [127:0] tgt_id;
  logic         drv_en, drv_bit, da_chg, all_assigned;
  logic [15:0]  tgt_dyn_addr;
  logic [0:0]   da_chg_idx;
  logic [3:0]   err_cnt;
  int           total = 0, bad = 0;
  logic         watch = 0, seen_en = 0, seen_chg = 0;

  localparam logic [63:0] ID0 = 64'h0000_1234_5678_9A00;
  localparam logic [63:0] ID1 = 64'h0000_1234_5678_9B00;
`ifdef I3C_DAA_ERRCNT_EN
  localparam logic [3:0] ERR1 = 4'd1;
`else
  localparam logic [3:0] ERR1 = 4'd0;
`endif

  always #5 clk_SCL = ~clk_SCL;

  i3c_daa_multi_slave dut (
    .clk_SCL      (clk_SCL),
    .RSTn         (RSTn),
    .bit_tick     (bit_tick),
    .sda_in       (sda_in),
    .daa_active   (daa_active),
    .daa_rstart   (daa_rstart),
    .rstdaa       (rstdaa),
    .set_da       (set_da),
    .set_idx      (set_idx),
    .new_da       (new_da),
    .tgt_id       (tgt_id),
    .drv_en       (drv_en),
    .drv_bit      (drv_bit),
    .tgt_dyn_addr (tgt_dyn_addr),
    .da_chg       (da_chg),
    .da_chg_idx   (da_chg_idx),
    .all_assigned (all_assigned),
    .err_cnt      (err_cnt)
  );

  always @(negedge clk_SCL) if (watch) begin
    seen_en  = seen_en | drv_en;
    seen_chg = seen_chg | da_chg;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_SCL);
    #1;
  endtask

  task automatic send(input logic b);
    bit_tick = 1;
    sda_in   = b;
    step();
    bit_tick = 0;
    step();
  endtask

  task automatic rstart();
    daa_rstart = 1;
    step();
    daa_rstart = 0;
    step();
  endtask

  task automatic id_phase(input int hi, input int lo, input int force_bit, input int peek_bit, input logic peek_exp);
    for (int i = hi; i >= lo; i--) begin
      if (i == peek_bit) begin
        chk($sformatf("wand_en_b%0d", i), drv_en, 1);
        chk($sformatf("wand_b%0d", i), drv_bit, peek_exp);
      end
      send(i == force_bit ? 1'b0 : drv_bit);
    end
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic p);
    for (int i = 6; i >= 0; i--) send(a[i]);
    send(p);
  endtask

  task automatic ack_tick();
    bit_tick = 1;
    sda_in   = drv_bit;
    step();
    bit_tick = 0;
    set_da   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tgt_id = {ID1, ID0};
    step();
    step();
    chk("rst_drv_en", drv_en, 0);
    chk("rst_drv_bit", drv_bit, 1);
    chk("rst_dyn", tgt_dyn_addr, 16'h0000);
    chk("rst_chg", da_chg, 0);
    chk("rst_err", err_cnt, 0);
    RSTn = 1;
    daa_active = 1;
    step();
    // round 1: both contend, target1 drops at bit 8, target0 gets 0x0A
    rstart();
    id_phase(63, 0, -1, 8, 1'b0);
    chk("t1_addr_en", drv_en, 0);
    addr_phase(7'h0A, 1'b1);
    chk("t1_ack_en", drv_en, 1);
    chk("t1_ack_bit", drv_bit, 0);
    ack_tick();
    chk("t1_chg", da_chg, 1);
    chk("t1_idx", da_chg_idx, 0);
    chk("t1_tgt0", tgt_dyn_addr[7:0], 8'h15);
    chk("t1_tgt1", tgt_dyn_addr[15:8], 8'h00);
    step();
    chk("t1_chg_end", da_chg, 0);
    // round 2: target1 alone, addr 0x0B (three ones -> parity 0)
    rstart();
    id_phase(63, 0, -1, 8, 1'b1);
    addr_phase(7'h0B, 1'b0);
    chk("t2_ack_bit", drv_bit, 0);
    ack_tick();
    chk("t2_chg", da_chg, 1);
    chk("t2_idx", da_chg_idx, 1);
    chk("t2_tgt1", tgt_dyn_addr[15:8], 8'h17);
    chk("t2_all", all_assigned, 1);
    step();
    // clear table, then lose arbitration to an external device at bit 40
    rstdaa = 1;
    step();
    rstdaa = 0;
    chk("clr_chg", da_chg, 1);
    chk("clr_idx", da_chg_idx, 1);
    chk("clr_valid", {tgt_dyn_addr[8], tgt_dyn_addr[0]}, 2'b00);
    step();
    tgt_id = {64'h0000_FFFF_0000_0002, 64'h0000_FFFF_0000_0001};
    rstart();
    id_phase(63, 40, 40, 40, 1'b1);
    chk("t3_lost_en", drv_en, 0);
    watch = 1;
    id_phase(39, 0, -1, -1, 1'b0);
    addr_phase(7'h05, 1'b1);
    send(1'b1);
    watch = 0;
    chk("t3_no_drive", seen_en, 0);
    chk("t3_no_chg", seen_chg, 0);
    chk("t3_valid", {tgt_dyn_addr[8], tgt_dyn_addr[0]}, 2'b00);
    daa_active = 0;
    step();
    daa_active = 1;
    step();
    tgt_id = {ID1, ID0};
    // bad parity: 0x22 has two ones, parity 0 is wrong -> NACK, then retry
    rstart();
    id_phase(63, 0, -1, -1, 1'b0);
    addr_phase(7'h22, 1'b0);
    chk("t4_nack_en", drv_en, 1);
    chk("t4_nack_bit", drv_bit, 1);
    ack_tick();
    chk("t4_no_chg", da_chg, 0);
    chk("t4_valid0", tgt_dyn_addr[0], 0);
    chk("t4_err", err_cnt, ERR1);
    step();
    rstart();
    id_phase(63, 0, -1, -1, 1'b0);
    addr_phase(7'h22, 1'b1);
    chk("t4_ack_bit", drv_bit, 0);
    ack_tick();
    chk("t4_retry_chg", da_chg, 1);
    chk("t4_retry_tgt0", tgt_dyn_addr[7:0], 8'h45);
    step();
    // set_da idx0 collides with a commit to idx1: idx0 first, idx1 one cycle later
    rstart();
    id_phase(63, 0, -1, 8, 1'b1);
    addr_phase(7'h0B, 1'b0);
    set_da  = 1;
    set_idx = 1'b0;
    new_da  = 7'h30;
    ack_tick();
    chk("t5_chg_a", da_chg, 1);
    chk("t5_idx_a", da_chg_idx, 0);
    chk("t5_tgt0", tgt_dyn_addr[7:0], 8'h61);
    chk("t5_tgt1_wait", tgt_dyn_addr[8], 0);
    step();
    chk("t5_chg_b", da_chg, 1);
    chk("t5_idx_b", da_chg_idx, 1);
    chk("t5_tgt1", tgt_dyn_addr[15:8], 8'h17);
    step();
    chk("t5_chg_end", da_chg, 0);
    // rstdaa in the middle of ADDR
    rstdaa = 1;
    step();
    rstdaa = 0;
    set_da = 1;
    set_idx = 1'b0;
    new_da = 7'h30;
    step();
    set_da = 0;
    step();
    rstart();
    id_phase(63, 0, -1, -1, 1'b0);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    rstdaa = 1;
    step();
    rstdaa = 0;
    chk("t6_chg", da_chg, 1);
    chk("t6_idx", da_chg_idx, 1);
    chk("t6_valid", {tgt_dyn_addr[8], tgt_dyn_addr[0]}, 2'b00);
    chk("t6_all", all_assigned, 0);
    chk("t6_err", err_cnt, 0);
    step();
    daa_active = 0;
    step();
    daa_active = 1;
    step();
    // daa_active falling mid-ID drops the drive
    rstart();
    id_phase(63, 60, -1, -1, 1'b0);
    chk("t6_id_en", drv_en, 1);
    daa_active = 0;
    step();
    chk("t6_off_en", drv_en, 0);
    daa_active = 1;
    step();
    chk("t6_idle_en", drv_en, 0);
    // reset mid-round
    set_da = 1;
    set_idx = 1'b1;
    new_da = 7'h11;
    step();
    set_da = 0;
    chk("t7_set", tgt_dyn_addr[15:8], 8'h23);
    rstart();
    id_phase(63, 50, -1, -1, 1'b0);
    chk("t7_id_en", drv_en, 1);
    RSTn = 0;
    step();
    chk("t7_rst_en", drv_en, 0);
    chk("t7_rst_dyn", tgt_dyn_addr, 16'h0000);
    RSTn = 1;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
